ifetch_unit: RTL and testbench

- Instruction-fetch stage that drives the word address of the instruction ROM and consumes its registered (1-cycle latency) read data.
- Tags each returned word with its byte PC and buffers it in a small fetch queue.
- Presents instructions to decode over a valid/ready handshake.
- Supports PC redirect (branch/jump), which flushes everything in flight.

---
 rtl/ifetch_unit_pkg.sv | 21 ++
 rtl/ifetch_fifo.sv | 75 +++++++
 rtl/ifetch_unit.sv | 94 +++++++++
 tb/tb_ifetch_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ifetch_unit_pkg.sv
// Shared constants and the fetch-queue entry type for the instruction-fetch stage.
// No ports; imported by ifetch_fifo and ifetch_unit.
package ifetch_unit_pkg;

  localparam int unsigned PC_W       = 32;
  localparam int unsigned INST_W     = 32;
  localparam int unsigned WORD_SHIFT = 2;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  // One buffered instruction: the fetched word tagged with its byte PC.
  typedef struct packed {
    logic [INST_W-1:0] data;
    logic [PC_W-1:0]   pc;
  } fq_entry_t;

  // Clear the byte-offset bits so a PC always points at a whole word.
  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] pc);
    return pc & ~PC_W'(3);
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Fetch queue: DEPTH-entry synchronous FIFO of fq_entry_t, head held in entry 0.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   flush        drop all entries (wins over push/pop)
//   push, din    write one entry at the tail
//   pop          remove the head (only honoured while valid)
//   head, valid  registered head entry and non-empty flag
//   count        number of buffered entries
module ifetch_fifo
  import ifetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  fq_entry_t     din,
  input  logic          pop,
  output fq_entry_t     head,
  output logic          valid,
  output logic [CW-1:0] count
);

  fq_entry_t     q   [DEPTH];
  fq_entry_t     q_n [DEPTH];
  logic [CW-1:0] count_n;
  logic [CW-1:0] wr_idx;
  logic          valid_n;
  logic          do_pop;

  // Shift-register queue: a pop moves every entry one slot toward the head,
  // and a push lands just behind the last entry that survives the pop.
  always_comb begin
    q_n     = q;
    count_n = count;
    do_pop  = pop & valid;
    wr_idx  = count - CW'(do_pop);
    if (flush) begin
      count_n = '0;
    end else begin
      if (do_pop) begin
        for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
          q_n[i] = q[i+1];
        end
      end
      if (push) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (CW'(i) == wr_idx) q_n[i] = din;
        end
      end
      count_n = count + CW'(push) - CW'(do_pop);
    end
    valid_n = (count_n != '0);
  end

  // Queue storage, occupancy and valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
      count <= '0;
      valid <= 1'b0;
    end else begin
      q     <= q_n;
      count <= count_n;
      valid <= valid_n;
    end
  end

  assign head = q[0];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: addresses a 1-cycle-latency ROM, tags returned words
// with their byte PC, buffers them and hands them to decode over valid/ready.
// Ports:
//   CLK, RSTN                 clock, async active-low reset
//   fetch_en                  allow new ROM requests
//   rom_a / rom_q             ROM word address / registered read data
//   redirect_valid/_pc        load a new PC and flush everything in flight
//   inst_valid/ready/data/pc  decode handshake and head instruction
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH = 2,
  parameter int unsigned ROM_AW   = 32
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              fetch_en,
  output logic [ROM_AW-1:0] rom_a,
  input  logic [31:0]       rom_q,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_data,
  output logic [31:0]       inst_pc
);

  localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
  localparam int unsigned OW = CW + 1;

  logic [PC_W-1:0] fetch_pc, fetch_pc_n;
  logic [PC_W-1:0] inflight_pc, inflight_pc_n;
  logic            inflight, inflight_n;
  logic [CW-1:0]   fq_count;
  logic [OW-1:0]   occ_c;
  logic            pop_c, push_c, issue_c;
  fq_entry_t       push_entry, head;

  // Issue only if the queue can absorb this request's word next cycle,
  // counting the word already in flight and the slot freed by this cycle's pop.
  always_comb begin
    pop_c         = inst_valid & inst_ready & ~redirect_valid;
    push_c        = inflight & ~redirect_valid;
    occ_c         = OW'(fq_count) + OW'(inflight) - OW'(inst_valid & inst_ready);
    issue_c       = fetch_en & ~redirect_valid & (occ_c < OW'(FQ_DEPTH));
    fetch_pc_n    = fetch_pc;
    inflight_pc_n = inflight_pc;
    inflight_n    = issue_c;
    if (redirect_valid) begin
      fetch_pc_n = word_align(redirect_pc);
      inflight_n = 1'b0;
    end else if (issue_c) begin
      inflight_pc_n = fetch_pc;
      fetch_pc_n    = fetch_pc + PC_W'(4);
    end
    push_entry.data = rom_q;
    push_entry.pc   = inflight_pc;
  end

  // PC and in-flight request tracking.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      fetch_pc    <= word_align(RESET_PC);
      inflight_pc <= '0;
      inflight    <= 1'b0;
    end else begin
      fetch_pc    <= fetch_pc_n;
      inflight_pc <= inflight_pc_n;
      inflight    <= inflight_n;
    end
  end

  // The ROM is read every cycle; the result only matters when a request was issued.
  assign rom_a = ROM_AW'(fetch_pc >> WORD_SHIFT);

  ifetch_fifo #(
    .DEPTH (FQ_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RSTN),
    .flush (redirect_valid),
    .push  (push_c),
    .din   (push_entry),
    .pop   (pop_c),
    .head  (head),
    .valid (inst_valid),
    .count (fq_count)
  );

  assign inst_data = head.data;
  assign inst_pc   = head.pc;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: behavioural ROM, expected-PC scoreboard
// loaded on reset/redirect and drained on every decode handshake, plus directed
// latency and state checks.
module tb_ifetch_unit;

  localparam int unsigned FQ_DEPTH = 2;

  logic        CLK;
  logic        RSTN;
  logic        fetch_en;
  logic [31:0] rom_a;
  logic [31:0] rom_q;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  ifetch_unit #(
    .RESET_PC (32'h0000_0000),
    .FQ_DEPTH (FQ_DEPTH),
    .ROM_AW   (32)
  ) dut (
    .CLK            (CLK),
    .RSTN           (RSTN),
    .fetch_en       (fetch_en),
    .rom_a          (rom_a),
    .rom_q          (rom_q),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] rom_val(input logic [31:0] w);
    return 32'hA000_0000 ^ (w * 32'h0001_0003);
  endfunction

  // Registered ROM, one cycle of read latency.
  always @(posedge CLK) rom_q <= rom_val(rom_a);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic load_stream(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard: every accepted instruction must be the next expected PC with its ROM word.
  always @(negedge CLK) begin
    logic [31:0] exp_pc;
    if (RSTN) begin
      check("no_overflow", (int'(dut.u_fifo.count) <= FQ_DEPTH) ? 32'd1 : 32'd0, 32'd1);
      if (inst_valid && inst_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          check("sb_empty", inst_pc, 32'hFFFF_FFFF);
        end else begin
          exp_pc = exp_q.pop_front();
          check("sb_pc", inst_pc, exp_pc);
          check("sb_data", inst_data, rom_val(exp_pc >> 2));
        end
      end
    end
  end

  initial begin
    RSTN           = 1'b0;
    fetch_en       = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (3) tick();
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_data", inst_data, 32'd0);
    check("rst_pc", inst_pc, 32'd0);
    check("rst_rom_a", rom_a, 32'd0);

    // Sequential stream from reset, ready held high.
    fetch_en   = 1'b1;
    inst_ready = 1'b1;
    load_stream(32'h0);
    RSTN = 1'b1;
    tick();
    check("lat_v0", {31'd0, inst_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("seq_valid", {31'd0, inst_valid}, 32'd1);
      check("seq_pc", inst_pc, 32'(4 * i));
      check("seq_data", inst_data, rom_val(32'(i)));
    end

    // Decode stalled after reset: queue fills and the PC stops.
    RSTN       = 1'b0;
    inst_ready = 1'b0;
    tick();
    load_stream(32'h0);
    RSTN = 1'b1;
    repeat (10) tick();
    check("stall_valid", {31'd0, inst_valid}, 32'd1);
    check("stall_pc", inst_pc, 32'h0);
    check("stall_data", inst_data, rom_val(32'h0));
    check("stall_count", 32'(dut.u_fifo.count), FQ_DEPTH);
    check("stall_rom_a", rom_a, 32'd2);
    inst_ready = 1'b1;
    tick();
    check("resume_pc1", inst_pc, 32'h4);
    tick();
    check("resume_pc2", inst_pc, 32'h8);
    repeat (3) tick();

    // Redirect mid-stream to a misaligned target.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h43;
    load_stream(32'h40);
    tick();
    redirect_valid = 1'b0;
    check("redir_v0", {31'd0, inst_valid}, 32'd0);
    tick();
    check("redir_v1", {31'd0, inst_valid}, 32'd0);
    tick();
    check("redir_valid", {31'd0, inst_valid}, 32'd1);
    check("redir_pc", inst_pc, 32'h40);
    check("redir_data", inst_data, rom_val(32'h10));
    repeat (4) tick();

    // Redirect together with a pop, then a second redirect that must win.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    load_stream(32'h200);
    tick();
    redirect_pc = 32'h80;
    load_stream(32'h80);
    tick();
    redirect_valid = 1'b0;
    check("dbl_v0", {31'd0, inst_valid}, 32'd0);
    tick();
    check("dbl_v1", {31'd0, inst_valid}, 32'd0);
    tick();
    check("dbl_valid", {31'd0, inst_valid}, 32'd1);
    check("dbl_pc", inst_pc, 32'h80);
    repeat (5) tick();

    // Fetch disabled mid-stream: pending words drain, then resume without a skip.
    fetch_en = 1'b0;
    repeat (5) tick();
    check("fen_drained", {31'd0, inst_valid}, 32'd0);
    check("fen_rom_a", rom_a, exp_q[0] >> 2);
    fetch_en = 1'b1;
    repeat (8) tick();
    check("fen_resumed", {31'd0, inst_valid}, 32'd1);

    // Asynchronous reset mid-stream.
    #2;
    RSTN = 1'b0;
    #1;
    check("arst_valid", {31'd0, inst_valid}, 32'd0);
    check("arst_data", inst_data, 32'd0);
    check("arst_pc", inst_pc, 32'd0);
    check("arst_rom_a", rom_a, 32'd0);
    tick();
    load_stream(32'h0);
    RSTN = 1'b1;
    tick();
    check("arst_lat_v0", {31'd0, inst_valid}, 32'd0);
    tick();
    check("arst_lat_v1", {31'd0, inst_valid}, 32'd1);
    check("arst_lat_pc", inst_pc, 32'h0);
    check("arst_lat_data", inst_data, rom_val(32'h0));
    repeat (6) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
